// File: rtl/axis_uart_pkg.sv
// Shared types and default framing bytes for the AXI4-Stream UART deframer.
package axis_uart_pkg;

  // Frame parser states
  typedef enum logic [1:0] {
    StIdle,
    StGetId,
    StData,
    StEsc
  } state_e;

  localparam logic [7:0] C_START_BYTE  = 8'h7D;
  localparam logic [7:0] C_STOP_BYTE   = 8'h7E;
  localparam logic [7:0] C_ESCAPE_BYTE = 8'h7F;

endpackage

// File: rtl/axis_uart_deframer.sv
// AXI4-Stream UART deframer: strips START/ID/STOP framing and escape bytes from the
// received byte stream and emits tid-tagged packets with tlast.
// Optional statistics counters are enabled by defining AXIS_UART_DEFRAMER_STATS_EN.
module axis_uart_deframer
  import axis_uart_pkg::*;
#(
  parameter logic [7:0]  START_BYTE  = C_START_BYTE,
  parameter logic [7:0]  STOP_BYTE   = C_STOP_BYTE,
  parameter logic [7:0]  ESCAPE_BYTE = C_ESCAPE_BYTE,
  // Low ID_WIDTH bits of the ID byte are kept; legal range 1..8
  parameter int unsigned ID_WIDTH    = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                rxbyte_tvalid,
  output logic                rxbyte_tready,
  input  logic [7:0]          rxbyte_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [7:0]          m_tdata,
  output logic                m_tlast,
`ifdef AXIS_UART_DEFRAMER_STATS_EN
  output logic [15:0]         frame_cnt,
  output logic [15:0]         abort_cnt,
`endif
  output logic [ID_WIDTH-1:0] m_tid
);

  state_e              r_state;
  logic [ID_WIDTH-1:0] r_id;
  logic [7:0]          r_pend_data;
  logic                r_pend_valid;
  logic                r_m_tvalid;
  logic [7:0]          r_m_tdata;
  logic                r_m_tlast;
  logic [ID_WIDTH-1:0] r_m_tid;

  state_e              w_state_nxt;
  logic [ID_WIDTH-1:0] w_id_nxt;
  logic [7:0]          w_pend_data_nxt;
  logic                w_pend_valid_nxt;
  logic                w_tready;
  logic                w_accept;
  logic                w_load;
  logic                w_load_last;
  logic                w_abort;
  logic                w_payload;
  logic                w_close;

  // Output slot can take a new beat when empty or draining this cycle
  assign w_tready      = aresetn & (~r_m_tvalid | m_tready);
  assign w_accept      = rxbyte_tvalid & w_tready;
  assign rxbyte_tready = w_tready;

  assign m_tvalid = r_m_tvalid;
  assign m_tdata  = r_m_tdata;
  assign m_tlast  = r_m_tlast;
  assign m_tid    = r_m_tid;

  // Next-state decode: parser transitions, pending-byte update and output load requests
  always_comb begin
    w_state_nxt      = r_state;
    w_id_nxt         = r_id;
    w_pend_data_nxt  = r_pend_data;
    w_pend_valid_nxt = r_pend_valid;
    w_load           = 1'b0;
    w_load_last      = 1'b0;
    w_abort          = 1'b0;
    w_payload        = 1'b0;
    w_close          = 1'b0;

    if (w_accept) begin
      unique case (r_state)
        StIdle: begin
          if (rxbyte_tdata == START_BYTE) w_state_nxt = StGetId;
        end
        StGetId: begin
          // ID byte is never escaped, even if it equals a marker
          w_id_nxt    = rxbyte_tdata[ID_WIDTH-1:0];
          w_state_nxt = StData;
        end
        StData: begin
          if (rxbyte_tdata == ESCAPE_BYTE) begin
            w_state_nxt = StEsc;
          end else if (rxbyte_tdata == STOP_BYTE) begin
            w_close     = 1'b1;
            w_state_nxt = StIdle;
          end else if (rxbyte_tdata == START_BYTE) begin
            // Truncated packet: close what we have, then take the new header
            w_close     = 1'b1;
            w_abort     = 1'b1;
            w_state_nxt = StGetId;
          end else begin
            w_payload = 1'b1;
          end
        end
        StEsc: begin
          w_payload   = 1'b1;
          w_state_nxt = StData;
        end
        default: w_state_nxt = StIdle;
      endcase
    end

    // A new payload byte pushes the previous one out as a non-final beat
    if (w_payload) begin
      w_load           = r_pend_valid;
      w_load_last      = 1'b0;
      w_pend_data_nxt  = rxbyte_tdata;
      w_pend_valid_nxt = 1'b1;
    end

    // STOP or abort flushes the pending byte as the final beat; empty frames emit nothing
    if (w_close) begin
      w_load           = r_pend_valid;
      w_load_last      = 1'b1;
      w_pend_valid_nxt = 1'b0;
    end
  end

  // Parser state, frame ID and pending lookahead byte
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= StIdle;
      r_id         <= '0;
      r_pend_data  <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_id         <= w_id_nxt;
      r_pend_data  <= w_pend_data_nxt;
      r_pend_valid <= w_pend_valid_nxt;
    end
  end

  // Output beat register; holds while stalled, tid captured with each beat
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
    end else if (w_load) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= r_pend_data;
      r_m_tlast  <= w_load_last;
      r_m_tid    <= r_id;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_UART_DEFRAMER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_abort_cnt;

  // Saturating counters of closed packets and START-triggered aborts
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (w_load && w_load_last && (r_frame_cnt != 16'hFFFF)) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_abort && (r_abort_cnt != 16'hFFFF)) r_abort_cnt <= r_abort_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign abort_cnt = r_abort_cnt;
`endif

endmodule

// File: tb/tb_axis_uart_deframer.sv
// Scoreboard bench for axis_uart_deframer: directed frames push expected beats into a
// queue; an independent monitor pops and compares each accepted output beat.
module tb_axis_uart_deframer;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] tid;
  } beat_t;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       rx_tvalid = 1'b0;
  logic       rx_tready;
  logic [7:0] rx_tdata = 8'h00;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tlast;
  logic [7:0] m_tid;
`ifdef AXIS_UART_DEFRAMER_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] abort_cnt;
`endif

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  bit    rand_ready = 1'b0;
  bit    fix_ready = 1'b1;

  axis_uart_deframer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .rxbyte_tvalid (rx_tvalid),
    .rxbyte_tready (rx_tready),
    .rxbyte_tdata  (rx_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tdata       (m_tdata),
    .m_tlast       (m_tlast),
`ifdef AXIS_UART_DEFRAMER_STATS_EN
    .frame_cnt     (frame_cnt),
    .abort_cnt     (abort_cnt),
`endif
    .m_tid         (m_tid)
  );

  always #5 aclk = ~aclk;

  // Downstream ready changes just after the active edge only
  always @(posedge aclk) begin
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : fix_ready;
  end

  // Monitor: checks accepted beats against the scoreboard and stability under stall
  beat_t held;
  bit    stalled = 1'b0;
  always @(negedge aclk) begin
    beat_t cur;
    beat_t exp;
    cur = '{data: m_tdata, last: m_tlast, tid: m_tid};
    if (!aresetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        n_vec++;
        if (!m_tvalid || cur != held) begin
          n_bad++;
          $display("FAIL stall_stable: got v=%0b d=%h l=%0b id=%h held d=%h l=%0b id=%h",
                   m_tvalid, cur.data, cur.last, cur.tid, held.data, held.last, held.tid);
        end
      end
      if (m_tvalid && m_tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: got d=%h l=%0b id=%h, none expected",
                   cur.data, cur.last, cur.tid);
        end else begin
          exp = exp_q.pop_front();
          if (cur != exp) begin
            n_bad++;
            $display("FAIL beat: got d=%h l=%0b id=%h expected d=%h l=%0b id=%h",
                     cur.data, cur.last, cur.tid, exp.data, exp.last, exp.tid);
          end
        end
        stalled = 1'b0;
      end else if (m_tvalid) begin
        stalled = 1'b1;
        held    = cur;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l, input logic [7:0] id);
    exp_q.push_back('{data: d, last: l, tid: id});
  endtask

  // Present one byte and hold it until accepted (bounded)
  task automatic send(input logic [7:0] b);
    int  t;
    bit  done;
    t    = 0;
    done = 1'b0;
    rx_tvalid = 1'b1;
    rx_tdata  = b;
    while (!done) begin
      @(negedge aclk);
      if (rx_tready) begin
        done = 1'b1;
      end else begin
        t++;
        if (t > 300) begin
          n_vec++;
          n_bad++;
          $display("FAIL send_timeout: byte %h not accepted, got ready=0 required 1", b);
          done = 1'b1;
        end
      end
      @(posedge aclk);
      #1;
    end
    rx_tvalid = 1'b0;
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) send(s[i]);
  endtask

  // Let all expected beats drain (bounded)
  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge aclk);
      t++;
    end
    repeat (3) @(posedge aclk);
    #1;
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s;
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tid", m_tid, 0);
    check("rst_rx_tready", rx_tready, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("post_rst_rx_tready", rx_tready, 1);

    // Plain frame
    expect_beat(8'h11, 1'b0, 8'h05);
    expect_beat(8'h22, 1'b0, 8'h05);
    expect_beat(8'h33, 1'b1, 8'h05);
    s = '{8'h7D, 8'h05, 8'h11, 8'h22, 8'h33, 8'h7E};
    send_seq(s);
    drain();

    // Escaped markers become literal payload
    expect_beat(8'h7E, 1'b0, 8'h02);
    expect_beat(8'h7D, 1'b0, 8'h02);
    expect_beat(8'h44, 1'b1, 8'h02);
    s = '{8'h7D, 8'h02, 8'h7F, 8'h7E, 8'h7F, 8'h7D, 8'h44, 8'h7E};
    send_seq(s);
    drain();

    // Empty frame emits nothing; next frame carries its own ID
    expect_beat(8'hAA, 1'b1, 8'h04);
    s = '{8'h7D, 8'h03, 8'h7E, 8'h7D, 8'h04, 8'hAA, 8'h7E};
    send_seq(s);
    drain();

    // START mid-frame closes the truncated packet under the old ID
    expect_beat(8'hA1, 1'b0, 8'h01);
    expect_beat(8'hA2, 1'b1, 8'h01);
    expect_beat(8'hB1, 1'b1, 8'h09);
    s = '{8'h7D, 8'h01, 8'hA1, 8'hA2, 8'h7D, 8'h09, 8'hB1, 8'h7E};
    send_seq(s);
    drain();
`ifdef AXIS_UART_DEFRAMER_STATS_EN
    check("abort_cnt", abort_cnt, 1);
    check("frame_cnt", frame_cnt, 5);
`endif

    // Random back-pressure over escaped frames, with idle noise and marker-valued IDs
    rand_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      logic [7:0] id;
      int         len;
      s.delete();
      if ($urandom_range(0, 3) == 0) s.push_back(8'h55);
      id  = 8'($urandom_range(0, 255));
      len = $urandom_range(0, 5);
      s.push_back(8'h7D);
      s.push_back(id);
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(8'h7D, 8'h7F));
        else b = 8'($urandom_range(0, 255));
        if (b == 8'h7D || b == 8'h7E || b == 8'h7F) s.push_back(8'h7F);
        s.push_back(b);
        expect_beat(b, (i == len - 1), id);
      end
      s.push_back(8'h7E);
      send_seq(s);
    end
    rand_ready = 1'b0;
    fix_ready  = 1'b1;
    drain();

    // Reset mid-frame drops the partial packet, including a stalled beat
    fix_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    s = '{8'h7D, 8'h06, 8'hC1, 8'hC2};
    send_seq(s);
    repeat (2) @(posedge aclk);
    #1;
    check("stalled_beat_held", m_tvalid, 1);
    check("stalled_rx_tready", rx_tready, 0);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check("midrst_tvalid", m_tvalid, 0);
    check("midrst_tlast", m_tlast, 0);
    check("midrst_rx_tready", rx_tready, 0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn   = 1'b1;
    fix_ready = 1'b1;
    @(posedge aclk);
    #1;
    expect_beat(8'hD1, 1'b1, 8'h07);
    s = '{8'h7D, 8'h07, 8'hD1, 8'h7E};
    send_seq(s);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
